// File: rtl/zb_phy_pkg.sv
// rtl/zb_phy_pkg.sv - shared types and constants for the 802.15.4 transmit framer
package zb_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_PHR,
        ST_PAY,
        ST_FCS
    } frame_state_t;

    localparam logic [7:0]  SFD_DEFAULT      = 8'hA7;
    localparam logic [15:0] CRC16_POLY_REFL  = 16'h8408;
    // Low nibble of every octet leaves first.
    localparam logic        NIBBLE_LOW_FIRST = 1'b1;

    // Picks the first (second=0) or second (second=1) nibble of an octet in wire order.
    function automatic logic [3:0] nibble_of(input logic [7:0] octet, input logic second);
        nibble_of = (second == NIBBLE_LOW_FIRST) ? octet[7:4] : octet[3:0];
    endfunction

endpackage

// File: rtl/fcs_crc16.sv
// rtl/fcs_crc16.sv - combinational CRC-16/KERMIT update over one octet, LSB first
module fcs_crc16
    import zb_phy_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [15:0] crc_out
);

    // Fold the octet into the low byte, then run eight reflected shift steps.
    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ({1'b0, c[15:1]} ^ CRC16_POLY_REFL) : {1'b0, c[15:1]};
        end
        crc_out = c;
    end

endmodule

// File: rtl/phy_frame_builder.sv
// rtl/phy_frame_builder.sv - PPDU framer writing nibbles to the TX FIFO; FRAME_FCS_EN appends CRC-16 FCS
module phy_frame_builder
    import zb_phy_pkg::*;
#(
    parameter int         PREAMBLE_BYTES = 4,
    parameter logic [7:0] SFD_BYTE       = SFD_DEFAULT,
    parameter int         MAX_LEN        = 127
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic [6:0] inLength,
    input  logic [7:0] inByte,
    input  logic       inByteValid,
    output logic       outByteReady,
    input  logic       inFull,
    output logic [3:0] outData,
    output logic       outWriteEnable,
    output logic       outBusy,
    output logic       outDone,
    output logic       outError
);

`ifdef FRAME_FCS_EN
    localparam logic [7:0] LEN_ADD = 8'd2;
`else
    localparam logic [7:0] LEN_ADD = 8'd0;
`endif
    localparam logic [7:0] PRE_LAST  = 8'(2 * PREAMBLE_BYTES - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   phr_q, phr_d;
    logic [6:0]   rem_q, rem_d;
    logic [7:0]   hold_q, hold_d;
    logic         hi_q, hi_d;
    logic         pend_q, pend_d;
    logic [3:0]   data_q, data_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         wr;
    logic         ready;
    logic         xfer;
    logic [7:0]   len_ext;

`ifdef FRAME_FCS_EN
    logic [15:0]  crc_q, crc_d, crc_next;

    fcs_crc16 u_fcs_crc16 (
        .crc_in    (crc_q),
        .data_byte (inByte),
        .crc_out   (crc_next)
    );
`endif

    // data_q always holds the pending nibble; it leaves whenever the FIFO has room.
    assign wr      = pend_q & ~inFull & ~inReset;
    // A new octet may land when the holder is empty or its high nibble is leaving now.
    assign ready   = (state_q == ST_PAY) && (rem_q != 7'd0) && (!pend_q || (wr && hi_q)) && !inReset;
    assign xfer    = ready & inByteValid;
    assign len_ext = {1'b0, inLength} + LEN_ADD;

    assign outByteReady   = ready;
    assign outWriteEnable = wr;
    assign outData        = data_q;
    assign outBusy        = busy_q;
    assign outDone        = done_q;
    assign outError       = err_q;

    // Next-state logic: advance to the following nibble each time the pending one is written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phr_d   = phr_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        hi_d    = hi_q;
        pend_d  = pend_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef FRAME_FCS_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (inStart) begin
                    if (inLength == 7'd0 || len_ext > MAX_LEN_B) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_PRE;
                        cnt_d   = 8'd0;
                        phr_d   = len_ext;
                        rem_d   = inLength;
                        hi_d    = 1'b0;
                        pend_d  = 1'b1;
                        data_d  = 4'h0;
                        busy_d  = 1'b1;
`ifdef FRAME_FCS_EN
                        crc_d   = 16'h0000;
`endif
                    end
                end
            end
            ST_PRE: begin
                if (wr) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_SFD;
                        cnt_d   = 8'd0;
                        data_d  = nibble_of(SFD_BYTE, 1'b0);
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        data_d = 4'h0;
                    end
                end
            end
            ST_SFD: begin
                if (wr) begin
                    if (cnt_q == 8'd0) begin
                        cnt_d  = 8'd1;
                        data_d = nibble_of(SFD_BYTE, 1'b1);
                    end else begin
                        state_d = ST_PHR;
                        cnt_d   = 8'd0;
                        data_d  = nibble_of(phr_q, 1'b0);
                    end
                end
            end
            ST_PHR: begin
                if (wr) begin
                    if (cnt_q == 8'd0) begin
                        cnt_d  = 8'd1;
                        data_d = nibble_of(phr_q, 1'b1);
                    end else begin
                        state_d = ST_PAY;
                        cnt_d   = 8'd0;
                        pend_d  = 1'b0;
                    end
                end
            end
            ST_PAY: begin
                if (xfer) begin
                    hold_d = inByte;
                    hi_d   = 1'b0;
                    pend_d = 1'b1;
                    data_d = nibble_of(inByte, 1'b0);
                    rem_d  = rem_q - 7'd1;
`ifdef FRAME_FCS_EN
                    crc_d  = crc_next;
`endif
                end else if (wr) begin
                    if (!hi_q) begin
                        hi_d   = 1'b1;
                        data_d = nibble_of(hold_q, 1'b1);
                    end else begin
                        pend_d = 1'b0;
                        hi_d   = 1'b0;
                        if (rem_q == 7'd0) begin
`ifdef FRAME_FCS_EN
                            state_d = ST_FCS;
                            cnt_d   = 8'd0;
                            pend_d  = 1'b1;
                            data_d  = nibble_of(crc_q[7:0], 1'b0);
`else
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            data_d  = 4'h0;
`endif
                        end
                    end
                end
            end
`ifdef FRAME_FCS_EN
            ST_FCS: begin
                if (wr) begin
                    if (cnt_q == 8'd3) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                        pend_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        data_d  = 4'h0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        case (cnt_q)
                            8'd0:    data_d = nibble_of(crc_q[7:0], 1'b1);
                            8'd1:    data_d = nibble_of(crc_q[15:8], 1'b0);
                            default: data_d = nibble_of(crc_q[15:8], 1'b1);
                        endcase
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            phr_q   <= 8'd0;
            rem_q   <= 7'd0;
            hold_q  <= 8'd0;
            hi_q    <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef FRAME_FCS_EN
            crc_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phr_q   <= phr_d;
            rem_q   <= rem_d;
            hold_q  <= hold_d;
            hi_q    <= hi_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef FRAME_FCS_EN
            crc_q   <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_phy_frame_builder.sv
// tb/tb_phy_frame_builder.sv - scoreboard bench for phy_frame_builder
module tb_phy_frame_builder;

`ifdef FRAME_FCS_EN
    localparam int LEN_ADD = 2;
    localparam int LONG_LEN = 125;
`else
    localparam int LEN_ADD = 0;
    localparam int LONG_LEN = 127;
`endif

    logic       inClock = 1'b0;
    logic       inReset;
    logic       inStart;
    logic [6:0] inLength;
    logic [7:0] inByte;
    logic       inByteValid;
    logic       outByteReady;
    logic       inFull;
    logic [3:0] outData;
    logic       outWriteEnable;
    logic       outBusy;
    logic       outDone;
    logic       outError;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_wr_cyc = -10;
    int done_cyc = 0;
    int st_cyc = 0;
    int bytes_sent = 0;
    bit done_seen = 0;
    bit starve = 0;
    logic [3:0] exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] frame_bytes[128];

    phy_frame_builder dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inStart        (inStart),
        .inLength       (inLength),
        .inByte         (inByte),
        .inByteValid    (inByteValid),
        .outByteReady   (outByteReady),
        .inFull         (inFull),
        .outData        (outData),
        .outWriteEnable (outWriteEnable),
        .outBusy        (outBusy),
        .outDone        (outDone),
        .outError       (outError)
    );

    always #5 inClock = ~inClock;
    always @(posedge inClock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef FRAME_FCS_EN
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r = {1'b0, r[15:1]};
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction
`endif

    task automatic expect_frame(input int len);
        logic [7:0] phr;
        logic [7:0] b;
`ifdef FRAME_FCS_EN
        logic [15:0] crc;
        crc = 16'h0000;
`endif
        for (int i = 0; i < 8; i++) exp_q.push_back(4'h0);
        exp_q.push_back(4'h7);
        exp_q.push_back(4'hA);
        phr = 8'(len + LEN_ADD);
        exp_q.push_back(phr[3:0]);
        exp_q.push_back(phr[7:4]);
        for (int i = 0; i < len; i++) begin
            b = frame_bytes[i];
            exp_q.push_back(b[3:0]);
            exp_q.push_back(b[7:4]);
`ifdef FRAME_FCS_EN
            crc = crc_bits(crc, b);
`endif
        end
`ifdef FRAME_FCS_EN
        exp_q.push_back(crc[3:0]);
        exp_q.push_back(crc[7:4]);
        exp_q.push_back(crc[11:8]);
        exp_q.push_back(crc[15:12]);
`endif
    endtask

    task automatic start_frame(input int len);
        expect_frame(len);
        for (int i = 0; i < len; i++) pay_q.push_back(frame_bytes[i]);
        done_seen = 0;
        @(negedge inClock);
        inStart = 1'b1;
        inLength = 7'(len);
        st_cyc = cyc;
        @(negedge inClock);
        inStart = 1'b0;
        #3;
        check("busy_rise", outBusy, 1);
        check("first_write_enable", outWriteEnable, !inFull);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done_seen && n < budget) begin
            @(negedge inClock);
            #3;
            n++;
        end
        check(tag, done_seen, 1);
    endtask

    task automatic reject_start(input string tag, input int len);
        int w0;
        w0 = wr_count;
        @(negedge inClock);
        inStart = 1'b1;
        inLength = 7'(len);
        @(negedge inClock);
        inStart = 1'b0;
        #3;
        check({tag, "_error_pulse"}, outError, 1);
        check({tag, "_busy_low"}, outBusy, 0);
        @(negedge inClock);
        #3;
        check({tag, "_error_cleared"}, outError, 0);
        check({tag, "_busy_still_low"}, outBusy, 0);
        check({tag, "_no_writes"}, wr_count - w0, 0);
    endtask

    // Payload source: present the next octet, note a transfer when ready meets valid.
    initial begin
        inByteValid = 1'b0;
        inByte = 8'h00;
        forever begin
            @(negedge inClock);
            #1;
            if (pay_q.size() > 0 && !starve) begin
                inByteValid = 1'b1;
                inByte = pay_q[0];
            end else begin
                inByteValid = 1'b0;
                inByte = 8'h00;
            end
            #1;
            if (inByteValid && outByteReady) begin
                void'(pay_q.pop_front());
                bytes_sent++;
            end
        end
    end

    // Output monitor: compare every written nibble against the scoreboard.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge inClock);
            #2;
            if (outWriteEnable) begin
                check("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("nibble", outData, e);
                end
                wr_count++;
                last_wr_cyc = cyc;
            end
            if (inFull) check("write_while_full", outWriteEnable, 0);
            if (outDone) begin
                done_seen = 1;
                done_cyc = cyc;
                check("done_after_last_write", cyc, last_wr_cyc + 1);
                check("done_queue_empty", exp_q.size(), 0);
                check("busy_low_at_done", outBusy, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        int n;
        int w0;
        int b0;
        inReset = 1'b1;
        inStart = 1'b0;
        inLength = 7'd0;
        inFull = 1'b0;

        // Reset state
        repeat (2) @(negedge inClock);
        #3;
        check("rst_data", outData, 0);
        check("rst_we", outWriteEnable, 0);
        check("rst_busy", outBusy, 0);
        check("rst_done", outDone, 0);
        check("rst_error", outError, 0);
        check("rst_ready", outByteReady, 0);
        @(negedge inClock);
        inReset = 1'b0;
        repeat (2) @(negedge inClock);

        // Test 1: single octet 0x5C, no back-pressure
        frame_bytes[0] = 8'h5C;
        w0 = wr_count;
        start_frame(1);
        wait_done("t1_done", 200);
        t1 = done_cyc - st_cyc;
        check("t1_write_count", wr_count - w0, 14 + 2 * LEN_ADD);

        // Test 2: same frame, FIFO full for 3 cycles after the SFD low nibble
        @(negedge inClock);
        w0 = wr_count;
        start_frame(1);
        n = 0;
        while (wr_count < w0 + 9 && n < 100) begin
            @(negedge inClock);
            #3;
            n++;
        end
        check("t2_sfd_reached", int'(wr_count >= w0 + 9), 1);
        repeat (3) begin
            @(negedge inClock);
            inFull = 1'b1;
        end
        @(negedge inClock);
        inFull = 1'b0;
        wait_done("t2_done", 200);
        t2 = done_cyc - st_cyc;
        check("t2_stall_cycles", t2, t1 + 3);
        check("t2_write_count", wr_count - w0, 14 + 2 * LEN_ADD);

        // Test 3: rejected starts
        reject_start("len0", 0);
`ifdef FRAME_FCS_EN
        reject_start("len128", 126);
`endif

        // Test 4: "123456789"
        for (int i = 0; i < 9; i++) frame_bytes[i] = 8'h31 + 8'(i);
        start_frame(9);
        wait_done("t4_done", 300);

        // Test 6: payload starvation for 5 cycles after 2 of 4 octets
        for (int i = 0; i < 4; i++) frame_bytes[i] = 8'(8'hC3 ^ (8'(i) << 2));
        b0 = bytes_sent;
        start_frame(4);
        n = 0;
        while (bytes_sent < b0 + 2 && n < 100) begin
            @(negedge inClock);
            #3;
            n++;
        end
        check("t6_two_octets", bytes_sent - b0, 2);
        w0 = wr_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge inClock);
            starve = 1'b1;
            inStart = (i == 0);
            inLength = 7'd3;
            #3;
            check("t6_busy_held", outBusy, 1);
            if (i > 0) check("t6_no_error_when_busy", outError, 0);
        end
        check("t6_drain_writes", wr_count - w0, 2);
        @(negedge inClock);
        starve = 1'b0;
        inStart = 1'b0;
        wait_done("t6_done", 300);

        // Test 5: reset mid-payload, then a fresh 2-octet frame
        for (int i = 0; i < 5; i++) frame_bytes[i] = 8'h10 + 8'(i * 17);
        b0 = bytes_sent;
        start_frame(5);
        n = 0;
        while (bytes_sent < b0 + 3 && n < 100) begin
            @(negedge inClock);
            #3;
            n++;
        end
        check("t5_three_octets", bytes_sent - b0, 3);
        @(negedge inClock);
        inReset = 1'b1;
        exp_q.delete();
        pay_q.delete();
        w0 = wr_count;
        @(negedge inClock);
        #3;
        check("t5_rst_data", outData, 0);
        check("t5_rst_we", outWriteEnable, 0);
        check("t5_rst_busy", outBusy, 0);
        check("t5_rst_done", outDone, 0);
        check("t5_rst_error", outError, 0);
        check("t5_rst_ready", outByteReady, 0);
        check("t5_rst_no_writes", wr_count - w0, 0);
        @(negedge inClock);
        inReset = 1'b0;
        @(negedge inClock);
        frame_bytes[0] = 8'hE4;
        frame_bytes[1] = 8'h9B;
        w0 = wr_count;
        start_frame(2);
        wait_done("t5_new_done", 200);
        check("t5_new_write_count", wr_count - w0, 16 + 2 * LEN_ADD);

        // Longest accepted frame
        for (int i = 0; i < LONG_LEN; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
        start_frame(LONG_LEN);
        wait_done("long_done", 2000);

        repeat (3) @(negedge inClock);
        #3;
        check("final_scoreboard_empty", exp_q.size(), 0);
        check("final_payload_consumed", pay_q.size(), 0);
        check("final_idle", outBusy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
